mul_pipe: RTL
=============

Name: mul_pipe

Overview:
- Parametrised, pipelined integer multiplier with valid/ready handshake on both sides.
- Successor to the combinational 32-bit Wallace multiplier: configurable operand width and pipeline depth, four RISC-V style ops (MUL/MULH/MULHSU/MULHU), per-op tag, flush and backpressure.
- Sits between the execute-stage issue logic and writeback as a multi-cycle functional unit.

Parameters:
- WIDTH, 32, operand width in bits; legal values are 8, 16, 32 and 64.
- STAGES, 3, pipeline register ranks; this is the latency in cycles with no stall; legal range 1..4.
- TAG_W, 5, width of the sideband tag carried alongside each op.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous reset, active-high.
- flush  in  1  synchronous kill of every in-flight op.
- in_valid  in  1  request valid.
- in_ready  out  1  unit can accept a request this cycle.
- in_op  in  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
- in_a  in  WIDTH  multiplicand; treated as signed for MULH and MULHSU.
- in_b  in  WIDTH  multiplier; treated as signed for MULH only.
- in_tag  in  TAG_W  sideband, returned unchanged with the result.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_result  out  WIDTH  low half of the product for MUL; high half for the other three ops.
- out_product  out  2*WIDTH  full product, using the signedness of the op.
- out_tag  out  TAG_W  tag of the op being returned.
- busy  out  1  at least one stage holds a valid op.

Behaviour:
- Reset (rst=1 at an edge):
  - Every stage valid bit clears.
  - out_valid=0, out_result=0, out_product=0, out_tag=0, busy=0.
  - Any op in flight is dropped, including one mid-pipeline; nothing for it reaches the output.
- Advance condition: adv = !out_valid || out_ready.
  - When adv=1, all stages shift forward by one rank.
  - When adv=0, all stages hold, including data and tag.
  - A bubble in the middle of the pipe is not compressed while the output is stalled.
- in_ready = adv && !flush && !rst. An op is accepted when in_valid && in_ready.
- Latency: exactly STAGES cycles from the accept edge to out_valid=1, provided adv stays 1.
  - Throughput: one op per cycle.
  - Ops leave in acceptance order.
- Output stability: while out_valid && !out_ready, out_result, out_product and out_tag hold stable.
- Flush:
  - All stage valids clear at that edge; out_valid=0 next cycle.
  - in_ready=0 during the flush cycle, so a simultaneous in_valid is not accepted.
  - rst and flush together behave as rst.
- Arithmetic:
  - Each operand is extended to WIDTH+1 bits: sign-extended if it is signed for the op, zero-extended otherwise.
  - Partial products are formed from the extended operands.
  - Reduction uses a 3:2 carry-save tree, then one final carry-propagate add.
  - The product is taken modulo 2^(2*WIDTH).
  - MUL is identical for all signedness choices; use unsigned.
- Stage split:
  - Rank 1 registers the decoded operands plus op/tag and all partial-product rows.
  - Middle ranks register the CSA tree state at evenly divided layer boundaries.
  - The last rank registers the CPA output.
  - STAGES=1: the whole datapath is combinational into a single output rank.
- busy = OR of all stage valid bits, including the output rank.

Decomposition:
- Shared package mul_pkg:
  - op encoding constants MUL_OP_MUL, MUL_OP_MULH, MUL_OP_MULHSU, MUL_OP_MULHU;
  - the mul_op_t typedef;
  - a function giving operand signedness (a_signed, b_signed) per op.
- Sub-modules:
  - Reuse the existing CSA3T2 (parametrised WIDTH) for every tree layer and the existing Adder for the final CPA.
  - New sub-module mul_csa_tree: a WIDTH-generic reduction of N rows to 2, with a parameter selecting after which layers registers are inserted.

Test Plan (WIDTH=32, STAGES=3):
- MULHU with a=0xFFFFFFFF, b=0xFFFFFFFF, out_ready=1:
  - out_valid 3 cycles after accept;
  - out_product=0xFFFFFFFE00000001, out_result=0xFFFFFFFE.
- MULH with a=0xFFFFFFFF, b=0x00000002:
  - out_product=0xFFFFFFFFFFFFFFFE, out_result=0xFFFFFFFF.
  - The same operands with MUL give out_result=0xFFFFFFFE.
- MULHSU with a=0x80000000, b=0xFFFFFFFF:
  - out_product=0x8000000080000000, out_result=0x80000000.
- MULH with a=0x80000000, b=0x80000000:
  - out_product=0x4000000000000000, out_result=0x40000000.
- Backpressure stream: 8 back-to-back ops with tags 0..7; out_ready held low for 4 cycles midway.
  - in_ready drops while the output is stalled.
  - Outputs stay stable during the stall.
  - All 8 results appear in tag order, with no loss or duplication.
- Flush and reset mid-operation:
  - Flush with 3 ops in flight: no out_valid follows for them, and busy=0 the next cycle. A new op then returns after exactly 3 cycles.
  - Repeat with rst instead of flush: same result, and all outputs read 0 after reset.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared types and helpers for the pipelined multiplier.
// Op encoding, operand signedness and CSA-tree sizing functions.
package mul_pkg;

    typedef enum logic [1:0] {
        MUL_OP_MUL    = 2'b00,
        MUL_OP_MULH   = 2'b01,
        MUL_OP_MULHSU = 2'b10,
        MUL_OP_MULHU  = 2'b11
    } mul_op_t;

    // Returns {a_signed, b_signed}.
    function automatic logic [1:0] op_sign(mul_op_t op);
        logic [1:0] s;
        unique case (op)
            MUL_OP_MULH:   s = 2'b11;
            MUL_OP_MULHSU: s = 2'b10;
            default:       s = 2'b00;
        endcase
        return s;
    endfunction

    // Rows left after `layers` 3:2 layers starting from n rows.
    function automatic int csa_rows(int n, int layers);
        int r;
        r = n;
        for (int i = 0; i < layers; i++) r = r - r / 3;
        return r;
    endfunction

    function automatic int csa_layers(int n);
        int r;
        int l;
        r = n;
        l = 0;
        while (r > 2) begin
            r = r - r / 3;
            l++;
        end
        return l;
    endfunction

    // Registers sit at evenly spaced layer boundaries.
    function automatic bit reg_after(int l, int layers, int nreg);
        bit hit;
        hit = 1'b0;
        for (int k = 1; k <= nreg; k++)
            if (l == (k * layers) / (nreg + 1)) hit = 1'b1;
        return hit;
    endfunction

endpackage

// File: rtl/Adder.sv
// Carry-propagate adder, result modulo 2^WIDTH.
module Adder #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum
);
    assign sum = a + b;
endmodule

// File: rtl/CSA3T2.sv
// 3:2 carry-save compressor, bitwise; carry is returned unshifted.
module CSA3T2 #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] sum,
    output logic [WIDTH-1:0] carry
);
    assign sum   = a ^ b ^ c;
    assign carry = (a & b) | (a & c) | (b & c);
endmodule

// File: rtl/mul_csa_tree.sv
// Generic N-row to 2-row carry-save reduction with optional
// register ranks inserted after evenly spaced layers.
module mul_csa_tree
    import mul_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int ROWS  = 34,
    parameter int NREG  = 1
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic [ROWS*WIDTH-1:0] rows,
    output logic [WIDTH-1:0]      sum,
    output logic [WIDTH-1:0]      carry
);
    localparam int L = csa_layers(ROWS);

    logic [ROWS*WIDTH-1:0] lay [L+1];

    assign lay[0] = rows;

    for (genvar l = 1; l <= L; l++) begin : g_lay
        localparam int NI = csa_rows(ROWS, l - 1);
        localparam int G  = NI / 3;
        logic [ROWS*WIDTH-1:0] lay_d;

        for (genvar k = 0; k < G; k++) begin : g_csa
            logic [WIDTH-1:0] s;
            logic [WIDTH-1:0] c;
            CSA3T2 #(.WIDTH(WIDTH)) u_csa (
                .a    (lay[l-1][(3*k)*WIDTH +: WIDTH]),
                .b    (lay[l-1][(3*k+1)*WIDTH +: WIDTH]),
                .c    (lay[l-1][(3*k+2)*WIDTH +: WIDTH]),
                .sum  (s),
                .carry(c)
            );
            assign lay_d[(2*k)*WIDTH +: WIDTH]   = s;
            assign lay_d[(2*k+1)*WIDTH +: WIDTH] = {c[WIDTH-2:0], 1'b0};
        end

        for (genvar j = 3 * G; j < NI; j++) begin : g_pass
            assign lay_d[(j-G)*WIDTH +: WIDTH] = lay[l-1][j*WIDTH +: WIDTH];
        end

        assign lay_d[ROWS*WIDTH-1:(NI-G)*WIDTH] = '0;

        if (reg_after(l, L, NREG)) begin : g_reg
            logic [ROWS*WIDTH-1:0] lay_q;
            always_ff @(posedge clk) begin
                if (en) lay_q <= lay_d;
            end
            assign lay[l] = lay_q;
        end else begin : g_comb
            assign lay[l] = lay_d;
        end
    end

    assign sum   = lay[L][WIDTH-1:0];
    assign carry = lay[L][2*WIDTH-1:WIDTH];
endmodule

// File: rtl/mul_pipe.sv
// Pipelined MUL/MULH/MULHSU/MULHU unit with valid/ready on both
// sides, tag sideband, flush and output backpressure.
module mul_pipe
    import mul_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 3,
    parameter int TAG_W  = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         in_op,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_result,
    output logic [2*WIDTH-1:0] out_product,
    output logic [TAG_W-1:0]   out_tag,
    output logic               busy
);
    localparam int PW = 2 * WIDTH;
    localparam int N  = WIDTH + 2;

    logic             adv;
    logic             acc;
    logic [1:0]       sg;
    logic [PW-1:0]    a_ext;
    logic             b_top;
    logic [N*PW-1:0]  pp_d;
    logic [N*PW-1:0]  pp;
    logic [PW-1:0]    t_sum;
    logic [PW-1:0]    t_carry;
    logic [PW-1:0]    cpa;
    mul_op_t          cpa_op;
    logic [STAGES-1:0] vld_q;
    logic [STAGES-1:0] vld_d;
    mul_op_t          op_q  [STAGES];
    logic [TAG_W-1:0] tag_q [STAGES];
    logic [PW-1:0]    prod_q;
    logic [PW-1:0]    prod_d;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] res_d;

    assign adv      = !vld_q[STAGES-1] || out_ready;
    assign in_ready = adv && !flush && !rst;
    assign acc      = in_valid && in_ready;

    // A signed b contributes -b[W-1]*2^W: rows ~a<<W and 1<<W.
    always_comb begin
        sg    = op_sign(mul_op_t'(in_op));
        a_ext = sg[1] ? {{WIDTH{in_a[WIDTH-1]}}, in_a}
                      : {{WIDTH{1'b0}}, in_a};
        b_top = sg[0] & in_b[WIDTH-1];
        pp_d  = '0;
        for (int i = 0; i < WIDTH; i++)
            pp_d[i*PW +: PW] = in_b[i] ? a_ext << i : '0;
        pp_d[WIDTH*PW +: PW]     = b_top ? ~a_ext << WIDTH : '0;
        pp_d[(WIDTH+1)*PW +: PW] = b_top ? PW'(1) << WIDTH : '0;
    end

    if (STAGES > 1) begin : g_pp
        logic [N*PW-1:0] pp_q;
        always_ff @(posedge clk) begin
            if (adv) pp_q <= pp_d;
        end
        assign pp     = pp_q;
        assign cpa_op = op_q[STAGES-2];
    end else begin : g_nopp
        assign pp     = pp_d;
        assign cpa_op = mul_op_t'(in_op);
    end

    mul_csa_tree #(
        .WIDTH(PW),
        .ROWS (N),
        .NREG (STAGES > 2 ? STAGES - 2 : 0)
    ) u_tree (
        .clk  (clk),
        .en   (adv),
        .rows (pp),
        .sum  (t_sum),
        .carry(t_carry)
    );

    Adder #(.WIDTH(PW)) u_cpa (
        .a  (t_sum),
        .b  (t_carry),
        .sum(cpa)
    );

    always_comb begin
        prod_d = cpa;
        res_d  = (cpa_op == MUL_OP_MUL) ? cpa[WIDTH-1:0] : cpa[PW-1:WIDTH];
        vld_d  = '0;
        vld_d[0] = acc;
        for (int i = 1; i < STAGES; i++) vld_d[i] = vld_q[i-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q  <= '0;
            prod_q <= '0;
            res_q  <= '0;
            for (int i = 0; i < STAGES; i++) begin
                op_q[i]  <= MUL_OP_MUL;
                tag_q[i] <= '0;
            end
        end else begin
            if (flush)    vld_q <= '0;
            else if (adv) vld_q <= vld_d;
            if (adv) begin
                op_q[0]  <= mul_op_t'(in_op);
                tag_q[0] <= in_tag;
                for (int i = 1; i < STAGES; i++) begin
                    op_q[i]  <= op_q[i-1];
                    tag_q[i] <= tag_q[i-1];
                end
                prod_q <= prod_d;
                res_q  <= res_d;
            end
        end
    end

    assign out_valid   = vld_q[STAGES-1];
    assign out_result  = res_q;
    assign out_product = prod_q;
    assign out_tag     = tag_q[STAGES-1];
    assign busy        = |vld_q;
endmodule
